// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM tick source and the pwm_capture block.
// The master drives the tick enable and the waveform; the slave returns the measurement.
interface pwm_capture_if;
  logic       ce;
  logic       pwm_in;
  logic [3:0] d;
  logic       valid;
  logic       err;
  logic       stuck;

  modport master (output ce, pwm_in, input d, valid, err, stuck);
  modport slave  (input ce, pwm_in, output d, valid, err, stuck);
endinterface

// File: rtl/pwm_capture.sv
// Measures the duty code of an asynchronous PWM input, one period at a time, in CE ticks.
// It flags periods of the wrong length (ERR) and inputs with no rising edges (STUCK).
module pwm_capture #(
  parameter int unsigned PERIOD  = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  pwm_capture_if.slave bus_if
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_MEASURE = 1'b1;

  localparam logic [7:0] PERIOD_C     = 8'(PERIOD);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  logic       sync1_q, sync2_q;
  logic       prev_q, prev_d;
  logic [0:0] state_q, state_d;
  logic [7:0] period_cnt_q, period_cnt_d;
  logic [7:0] high_cnt_q, high_cnt_d;
  logic [7:0] idle_cnt_q, idle_cnt_d;
  logic [3:0] d_q, d_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic       stuck_q, stuck_d;
  logic       rise;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // The synchronizer runs every clock. prev only advances on CE ticks, so an edge is seen once per tick.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value, which forms a real 2-stage chain.
      sync1_q <= bus_if.pwm_in;
      sync2_q <= sync1_q;
    end
  end

  assign rise = sync2_q & ~prev_q;

  always_comb begin
    // NOTE: every next-state signal gets a hold default first, so no path leaves one unassigned and infers a latch.
    prev_d       = prev_q;
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    d_d          = d_q;
    err_d        = err_q;
    stuck_d      = stuck_q;
    valid_d      = 1'b0;

    if (bus_if.ce) begin
      prev_d = sync2_q;
      if (rise) begin
        // An edge always wins over a timeout on the same tick. It also restarts the measurement.
        if (state_q == ST_MEASURE) begin
          if (period_cnt_q == PERIOD_C) begin
            d_d     = (high_cnt_q > 8'd15) ? 4'hF : high_cnt_q[3:0];
            valid_d = 1'b1;
            err_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
        state_d      = ST_MEASURE;
        period_cnt_d = 8'd1;
        high_cnt_d   = 8'd1;
        idle_cnt_d   = 8'd0;
        stuck_d      = 1'b0;
      end else begin
        idle_cnt_d = sat_inc(idle_cnt_q);
        if (!stuck_q && idle_cnt_q == TIMEOUT_LAST) begin
          stuck_d      = 1'b1;
          d_d          = sync2_q ? 4'hF : 4'h0;
          valid_d      = 1'b1;
          state_d      = ST_IDLE;
          period_cnt_d = 8'd0;
          high_cnt_d   = 8'd0;
        end else if (state_q == ST_MEASURE) begin
          period_cnt_d = sat_inc(period_cnt_q);
          if (sync2_q) high_cnt_d = sat_inc(high_cnt_q);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q       <= 1'b0;
      state_q      <= ST_IDLE;
      period_cnt_q <= 8'd0;
      high_cnt_q   <= 8'd0;
      idle_cnt_q   <= 8'd0;
      d_q          <= 4'd0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      d_q          <= d_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      stuck_q      <= stuck_d;
    end
  end

  assign bus_if.d     = d_q;
  assign bus_if.valid = valid_q;
  assign bus_if.err   = err_q;
  assign bus_if.stuck = stuck_q;

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter PERIOD, default 16: expected PWM period in CE ticks (range 2..255).
REQ-002 Parameter TIMEOUT, default 64: CE ticks without a rising edge before declaring the input stuck (range PERIOD+1..255).
REQ-003 CLK  input  1  system clock; all state on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 CE  input  1  clock enable; one CE-high cycle = one PWM tick, same tick as the PWM generator.
REQ-006 PWM_IN  input  1  incoming PWM waveform, asynchronous to CLK.
REQ-007 D  output  4  last measured duty code: high ticks per period, 0..15.
REQ-008 VALID  output  1  one-CLK pulse when D has been updated from a good period.
REQ-009 ERR  output  1  sticky flag: last completed period length differed from PERIOD.
REQ-010 STUCK  output  1  level: no rising edge seen for TIMEOUT ticks.

Function
REQ-011 PWM_IN shall pass through a 2-flop synchronizer on CLK every cycle, regardless of CE; a third flop (prev) holds the last synced value sampled on a CE tick.
REQ-012 A rising edge is sync=1 and prev=1'b0 on a CE tick; prev updates only on CE ticks; edges between CE ticks are sampled at the next CE tick.
REQ-013 States: IDLE (no reference edge yet), MEASURE; reset enters IDLE.
REQ-014 IDLE: on rising edge go to MEASURE; set period_cnt=1, high_cnt=1; no VALID.
REQ-015 MEASURE, CE tick without edge: period_cnt+=1 and high_cnt+=1 if sync=1; both 8-bit, saturate at 255, no wrap.
REQ-016 MEASURE, CE tick with edge and period_cnt==PERIOD: D<=min(high_cnt,15); VALID=1 for the next CLK cycle only; ERR<=0; STUCK<=0.
REQ-017 MEASURE, CE tick with edge and period_cnt!=PERIOD: D unchanged; no VALID; ERR<=1; STUCK<=0.
REQ-018 Either edge case reloads period_cnt=1, high_cnt=1 on the same tick; state stays MEASURE.
REQ-019 Edge-to-VALID latency: VALID asserts the CLK cycle after the CE tick on which the edge is detected; PWM_IN pin to VALID is at most 3 CLK cycles plus wait-for-CE.
REQ-020 Timeout: ticks since last edge (or since reset) reaching TIMEOUT sets STUCK=1; D<=4'd15 if sync=1 else 4'd0; VALID pulses once on entry; state returns to IDLE; ERR unchanged.
REQ-021 While STUCK=1: no further VALID pulses; the next rising edge clears STUCK and follows REQ-014 (no VALID for that edge).
REQ-022 CE=0: counters, state, prev and outputs hold; only synchronizer flops move.
REQ-023 Glitch edges making period_cnt<PERIOD shall be reported via ERR only, never update D.
REQ-024 Timeout counter and period_cnt count in the same tick domain; on the tick where an edge and TIMEOUT coincide, the edge wins.

Reset
REQ-025 RST=1 shall asynchronously force: D=0, VALID=0, ERR=0, STUCK=0, state=IDLE, counters=0, synchronizer and prev flops=0.
REQ-026 RST deassertion takes effect on the next CLK edge; RST asserted mid-period discards the partial measurement, and no VALID is issued for it.

Verification
REQ-027 CE every 2nd CLK, PWM_IN = generator with code 4 (4 high / 12 low, PERIOD 16) -> first edge no VALID, then VALID every 16 ticks with D=4, ERR=0.
REQ-028 Sweep codes 1..15 from the generator, 3 periods each -> D matches each code from the 2nd VALID after each change; ERR stays 0.
REQ-029 PWM_IN held 0 after reset for 70 ticks -> STUCK=1 at tick 64, single VALID, D=0; then code 7 applied -> STUCK clears at first edge, D=7 one period later.
REQ-030 Code 9 running, PWM_IN forced 1 -> STUCK=1 64 ticks after last edge, D=15.
REQ-031 Inject a 1-tick low-high glitch mid-period -> ERR=1, D unchanged, no VALID; the next clean period gives VALID, ERR=0.
REQ-032 RST pulse asserted between CLK edges mid-period with code 5 -> all outputs 0 immediately; VALID with D=5 one full period after the first post-reset edge.
